// File: rtl/cpu_control.sv
// Multicycle CPU control unit: fetch/execute sequencer with memory handshake,
// conditional branches, link-register calls, a single vectored interrupt and HALT.

package cpu_control_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluShl  = 4'd5,
    AluShr  = 4'd6,
    AluAdc  = 4'd7,
    AluPass = 4'd8
  } alu_functions_t;

  typedef enum logic [1:0] {Pc1, PcAluOut, PcLr, PcInt} pc_sel_t;
  typedef enum logic {Op1Rd1, Op1Pc} op1_sel_t;
  typedef enum logic [1:0] {Op2Rd2, Op2Imm, Op2Zero} op2_sel_t;
  typedef enum logic {ImmShort, ImmLong} imm_sel_t;
  typedef enum logic {WdAlu, WdSys} wd_sel_t;
  typedef enum logic {Rs1Rd, Rs1Ra} rs1_sel_t;
  typedef enum logic {LrPc, LrSys} lr_sel_t;
  typedef enum logic {RwRd, RwWr} rw_sel_t;
  typedef enum logic {FlagAlu, FlagSys} flag_sel_t;

endpackage

module cpu_control
  import cpu_control_pkg::*;
(
  input  logic           Clock,
  input  logic           Reset,
  input  logic [7:0]     Opcode,
  input  logic [3:0]     Flags,
  input  logic           IntReq,
  input  logic           MemReady,
  output alu_functions_t AluOp,
  output pc_sel_t        PcSel,
  output op1_sel_t       Op1Sel,
  output op2_sel_t       Op2Sel,
  output imm_sel_t       ImmSel,
  output wd_sel_t        WdSel,
  output rs1_sel_t       Rs1Sel,
  output lr_sel_t        LrSel,
  output rw_sel_t        RwSel,
  output flag_sel_t      FlagSel,
  output logic           FlagListen,
  output logic           AluEn,
  output logic           AluWe,
  output logic           LrEn,
  output logic           LrWe,
  output logic           PcEn,
  output logic           PcWe,
  output logic           IrWe,
  output logic           RegWe,
  output logic           MemEn,
  output logic           CFlag,
  output logic           AddrLatch,
  output logic           MemRd,
  output logic           MemWr,
  output logic           IntAck,
  output logic           Illegal,
  output logic           Halted
);

  typedef enum logic [3:0] {
    StFetchA, StFetchD, StExec, StMemA, StMemRd, StStPrep, StMemWr, StInt, StHalt
  } state_t;

  state_t     stateQ;
  logic [3:0] flagsQ;
  logic       ieQ;
  logic       intTake;
  logic       condTrue;
  logic       unusedFlags;

  assign intTake    = IntReq && ieQ;
  assign CFlag      = flagsQ[1];
  assign RwSel      = RwRd;
  assign FlagSel    = FlagAlu;
  assign FlagListen = 1'b0;
  // V is captured with the rest of the flags but no branch condition tests it.
  assign unusedFlags = flagsQ[3];

  // Branch condition from the stored flags (never the live ALU flags).
  always_comb begin
    condTrue = 1'b0;
    case (Opcode[2:0])
      3'd0:    condTrue = 1'b1;
      3'd1:    condTrue = flagsQ[0];
      3'd2:    condTrue = !flagsQ[0];
      3'd3:    condTrue = flagsQ[1];
      3'd4:    condTrue = !flagsQ[1];
      3'd5:    condTrue = flagsQ[2];
      3'd6:    condTrue = !flagsQ[2];
      default: condTrue = 1'b0;
    endcase
  end

  // Sequencer state, stored flags and interrupt enable.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ <= StFetchA;
      flagsQ <= 4'b0000;
      ieQ    <= 1'b1;
    end else begin
      case (stateQ)
        StFetchA: stateQ <= intTake ? StInt : StFetchD;
        StFetchD: if (MemReady) stateQ <= StExec;
        StExec: begin
          if (!Opcode[7]) begin
            flagsQ <= Flags;
            stateQ <= StFetchA;
          end else if (!Opcode[6]) begin
            stateQ <= StMemA;
          end else begin
            stateQ <= StFetchA;
            if (Opcode[5:3] == 3'b011) ieQ <= 1'b1;
            if (Opcode[5:3] == 3'b100) stateQ <= StHalt;
          end
        end
        StMemA:   stateQ <= Opcode[5] ? StStPrep : StMemRd;
        StMemRd:  if (MemReady) stateQ <= StFetchA;
        StStPrep: stateQ <= StMemWr;
        StMemWr:  if (MemReady) stateQ <= StFetchA;
        StInt: begin
          ieQ    <= 1'b0;
          stateQ <= StFetchA;
        end
        StHalt:   if (intTake) stateQ <= StInt;
        default:  stateQ <= StFetchA;
      endcase
    end
  end

  // Datapath controls decoded from the current state, IR and handshakes.
  always_comb begin
    AluOp     = AluAdd;
    PcSel     = Pc1;
    Op1Sel    = Op1Rd1;
    Op2Sel    = Op2Rd2;
    ImmSel    = ImmShort;
    WdSel     = WdAlu;
    Rs1Sel    = Rs1Rd;
    LrSel     = LrPc;
    AluEn     = 1'b0;
    AluWe     = 1'b0;
    LrEn      = 1'b0;
    LrWe      = 1'b0;
    PcEn      = 1'b0;
    PcWe      = 1'b0;
    IrWe      = 1'b0;
    RegWe     = 1'b0;
    MemEn     = 1'b0;
    AddrLatch = 1'b0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    IntAck    = 1'b0;
    Illegal   = 1'b0;
    Halted    = 1'b0;
    if (!Reset) begin
      case (stateQ)
        StFetchA: begin
          if (!intTake) begin
            PcEn      = 1'b1;
            AddrLatch = 1'b1;
          end
        end
        StFetchD: begin
          MemEn = 1'b1;
          MemRd = 1'b1;
          if (MemReady) begin
            IrWe = 1'b1;
            PcWe = 1'b1;
          end
        end
        StExec: begin
          if (!Opcode[7]) begin
            AluOp = alu_functions_t'({1'b0, Opcode[5:3]});
            RegWe = 1'b1;
            if (Opcode[6]) Op2Sel = Op2Imm;
          end else if (!Opcode[6]) begin
            Rs1Sel = Rs1Ra;
            Op2Sel = Op2Imm;
            AluWe  = 1'b1;
          end else begin
            case (Opcode[5:3])
              3'b000, 3'b001: begin
                // Opcode[3] set means BL: unconditional, plus link save.
                if (Opcode[3] || condTrue) begin
                  Op1Sel = Op1Pc;
                  Op2Sel = Op2Imm;
                  ImmSel = ImmLong;
                  PcSel  = PcAluOut;
                  PcWe   = 1'b1;
                end
                if (Opcode[3]) LrWe = 1'b1;
              end
              3'b010, 3'b011: begin
                PcSel = PcLr;
                PcWe  = 1'b1;
              end
              3'b100: begin
              end
              default: Illegal = 1'b1;
            endcase
          end
        end
        StMemA: begin
          AluEn     = 1'b1;
          AddrLatch = 1'b1;
        end
        StMemRd: begin
          MemEn = 1'b1;
          MemRd = 1'b1;
          if (MemReady) begin
            WdSel = WdSys;
            RegWe = 1'b1;
          end
        end
        StStPrep: begin
          Op2Sel = Op2Zero;
          AluWe  = 1'b1;
        end
        StMemWr: begin
          AluEn = 1'b1;
          MemWr = 1'b1;
        end
        StInt: begin
          PcEn   = 1'b1;
          LrSel  = LrSys;
          LrWe   = 1'b1;
          PcSel  = PcInt;
          PcWe   = 1'b1;
          IntAck = 1'b1;
        end
        StHalt:  Halted = 1'b1;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: an instruction-level model expands each
// instruction into its expected per-cycle control trace, which is compared live.

module tb_cpu_control;
  import cpu_control_pkg::*;

  typedef struct packed {
    alu_functions_t AluOp;
    pc_sel_t        PcSel;
    op1_sel_t       Op1Sel;
    op2_sel_t       Op2Sel;
    imm_sel_t       ImmSel;
    wd_sel_t        WdSel;
    rs1_sel_t       Rs1Sel;
    lr_sel_t        LrSel;
    logic AluEn, AluWe, LrEn, LrWe, PcEn, PcWe, IrWe, RegWe, MemEn, CFlag;
    logic AddrLatch, MemRd, MemWr, IntAck, Illegal, Halted;
  } outs_t;

  typedef struct packed {
    outs_t      exp;
    logic       rst;
    logic       irq;
    logic       rdy;
    logic [3:0] flags;
    logic [7:0] op;
  } cyc_t;

  logic Clock, Reset, IntReq, MemReady;
  logic [7:0] Opcode;
  logic [3:0] Flags;
  alu_functions_t AluOp;
  pc_sel_t PcSel;
  op1_sel_t Op1Sel;
  op2_sel_t Op2Sel;
  imm_sel_t ImmSel;
  wd_sel_t WdSel;
  rs1_sel_t Rs1Sel;
  lr_sel_t LrSel;
  rw_sel_t RwSel;
  flag_sel_t FlagSel;
  logic FlagListen, AluEn, AluWe, LrEn, LrWe, PcEn, PcWe, IrWe, RegWe, MemEn, CFlag;
  logic AddrLatch, MemRd, MemWr, IntAck, Illegal, Halted;

  outs_t act;
  cyc_t  q[$];
  int    nPass, nTotal;
  logic [3:0] mFlags;
  logic       mIe;
  logic [7:0] mOp;

  cpu_control dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Flags(Flags), .IntReq(IntReq),
    .MemReady(MemReady), .AluOp(AluOp), .PcSel(PcSel), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel),
    .ImmSel(ImmSel), .WdSel(WdSel), .Rs1Sel(Rs1Sel), .LrSel(LrSel), .RwSel(RwSel),
    .FlagSel(FlagSel), .FlagListen(FlagListen), .AluEn(AluEn), .AluWe(AluWe), .LrEn(LrEn),
    .LrWe(LrWe), .PcEn(PcEn), .PcWe(PcWe), .IrWe(IrWe), .RegWe(RegWe), .MemEn(MemEn),
    .CFlag(CFlag), .AddrLatch(AddrLatch), .MemRd(MemRd), .MemWr(MemWr), .IntAck(IntAck),
    .Illegal(Illegal), .Halted(Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always_comb begin
    act.AluOp = AluOp;   act.PcSel = PcSel;     act.Op1Sel = Op1Sel; act.Op2Sel = Op2Sel;
    act.ImmSel = ImmSel; act.WdSel = WdSel;     act.Rs1Sel = Rs1Sel; act.LrSel = LrSel;
    act.AluEn = AluEn;   act.AluWe = AluWe;     act.LrEn = LrEn;     act.LrWe = LrWe;
    act.PcEn = PcEn;     act.PcWe = PcWe;       act.IrWe = IrWe;     act.RegWe = RegWe;
    act.MemEn = MemEn;   act.CFlag = CFlag;     act.AddrLatch = AddrLatch;
    act.MemRd = MemRd;   act.MemWr = MemWr;     act.IntAck = IntAck; act.Illegal = Illegal;
    act.Halted = Halted;
  end

  // ---------------- reference model ----------------
  function automatic outs_t dflt();
    outs_t d;
    d = '0;
    d.AluOp = AluAdd; d.PcSel = Pc1; d.Op1Sel = Op1Rd1; d.Op2Sel = Op2Rd2;
    d.ImmSel = ImmShort; d.WdSel = WdAlu; d.Rs1Sel = Rs1Rd; d.LrSel = LrPc;
    return d;
  endfunction

  function automatic logic rndb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rndf();
    return 4'($urandom_range(0, 15));
  endfunction

  // mode 0: IntReq low, 1: random, 2: held high
  function automatic logic irqv(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return rndb();
    return 1'b1;
  endfunction

  function automatic logic cond_holds(input logic [2:0] cc, input logic [3:0] f);
    logic z, c, n;
    z = f[0]; c = f[1]; n = f[2];
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input outs_t e, input logic rst, input logic irq, input logic rdy,
                      input logic [3:0] fl);
    cyc_t c;
    e.CFlag = mFlags[1];
    c.exp = e; c.rst = rst; c.irq = irq; c.rdy = rdy; c.flags = fl; c.op = mOp;
    q.push_back(c);
  endtask

  task automatic gen_int(input int mode);
    outs_t e;
    e = dflt();
    e.PcEn = 1'b1; e.LrSel = LrSys; e.LrWe = 1'b1; e.PcSel = PcInt; e.PcWe = 1'b1;
    e.IntAck = 1'b1;
    push(e, 1'b0, irqv(mode), rndb(), rndf());
    mIe = 1'b0;
  endtask

  task automatic gen_fetch(input int mode);
    outs_t e;
    logic r;
    for (int g = 0; g < 4; g++) begin
      r = irqv(mode);
      e = dflt();
      if (r && mIe) begin
        push(e, 1'b0, 1'b1, rndb(), rndf());
        gen_int(mode);
      end else begin
        e.PcEn = 1'b1; e.AddrLatch = 1'b1;
        push(e, 1'b0, r, rndb(), rndf());
        break;
      end
    end
  endtask

  task automatic gen_fetch_data(input int waits, input int mode);
    outs_t e;
    e = dflt();
    e.MemEn = 1'b1; e.MemRd = 1'b1;
    for (int i = 0; i < waits; i++) push(e, 1'b0, irqv(mode), 1'b0, rndf());
    e.IrWe = 1'b1; e.PcWe = 1'b1;
    push(e, 1'b0, irqv(mode), 1'b1, rndf());
  endtask

  task automatic gen_exec(input int memWait, input int mode, input logic [3:0] aluFl);
    outs_t e;
    int n;
    e = dflt();
    if (mOp[7] == 1'b0) begin
      e.AluOp = alu_functions_t'({1'b0, mOp[5:3]});
      e.RegWe = 1'b1;
      if (mOp[6]) e.Op2Sel = Op2Imm;
      push(e, 1'b0, irqv(mode), rndb(), aluFl);
      mFlags = aluFl;
    end else if (mOp[6] == 1'b0) begin
      e.Rs1Sel = Rs1Ra; e.Op2Sel = Op2Imm; e.AluWe = 1'b1;
      push(e, 1'b0, irqv(mode), rndb(), rndf());
      e = dflt(); e.AluEn = 1'b1; e.AddrLatch = 1'b1;
      push(e, 1'b0, irqv(mode), rndb(), rndf());
      if (mOp[5] == 1'b0) begin
        e = dflt(); e.MemEn = 1'b1; e.MemRd = 1'b1;
        for (int i = 0; i < memWait; i++) push(e, 1'b0, irqv(mode), 1'b0, rndf());
        e.WdSel = WdSys; e.RegWe = 1'b1;
        push(e, 1'b0, irqv(mode), 1'b1, rndf());
      end else begin
        e = dflt(); e.Op2Sel = Op2Zero; e.AluWe = 1'b1;
        push(e, 1'b0, irqv(mode), rndb(), rndf());
        e = dflt(); e.AluEn = 1'b1; e.MemWr = 1'b1;
        for (int i = 0; i < memWait; i++) push(e, 1'b0, irqv(mode), 1'b0, rndf());
        push(e, 1'b0, irqv(mode), 1'b1, rndf());
      end
    end else begin
      case (mOp[5:3])
        3'd0, 3'd1: begin
          if (mOp[3] || cond_holds(mOp[2:0], mFlags)) begin
            e.Op1Sel = Op1Pc; e.Op2Sel = Op2Imm; e.ImmSel = ImmLong;
            e.PcSel = PcAluOut; e.PcWe = 1'b1;
          end
          if (mOp[3]) begin e.LrSel = LrPc; e.LrWe = 1'b1; end
          push(e, 1'b0, irqv(mode), rndb(), rndf());
        end
        3'd2, 3'd3: begin
          e.PcSel = PcLr; e.PcWe = 1'b1;
          push(e, 1'b0, irqv(mode), rndb(), rndf());
          if (mOp[3]) mIe = 1'b1;
        end
        3'd4: begin
          push(e, 1'b0, irqv(mode), rndb(), rndf());
          e.Halted = 1'b1;
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) push(e, 1'b0, 1'b0, rndb(), rndf());
          if (mIe) begin
            push(e, 1'b0, 1'b1, rndb(), rndf());
            gen_int(mode);
          end else begin
            push(dflt(), 1'b1, rndb(), rndb(), rndf());
            mFlags = 4'b0000;
            mIe = 1'b1;
          end
        end
        default: begin
          e.Illegal = 1'b1;
          push(e, 1'b0, irqv(mode), rndb(), rndf());
        end
      endcase
    end
  endtask

  task automatic do_instr(input logic [7:0] op, input int fw, input int mw, input int mode,
                          input logic [3:0] aluFl);
    mOp = op;
    gen_fetch(mode);
    gen_fetch_data(fw, mode);
    gen_exec(mw, mode, aluFl);
  endtask

  task automatic play(output cyc_t c);
    @(posedge Clock);
    #1;
    c = q.pop_front();
    Reset = c.rst; Opcode = c.op; Flags = c.flags; IntReq = c.irq; MemReady = c.rdy;
    @(negedge Clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    outs_t e;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock);
      #1;
      Reset = 1'b1; Opcode = 8'($urandom); Flags = rndf(); IntReq = 1'b1; MemReady = 1'b1;
      @(negedge Clock);
      e = dflt();
      nTotal++;
      if (act !== e) $display("FAIL reset[%0d]: got %h expected %h", i, act, e);
      else nPass++;
    end
    nTotal++;
    if ({RwSel, FlagSel, FlagListen} !== {RwRd, FlagAlu, 1'b0})
      $display("FAIL tie_offs: got %b expected %b", {RwSel, FlagSel, FlagListen},
               {RwRd, FlagAlu, 1'b0});
    else nPass++;
    mFlags = 4'b0000;
    mIe = 1'b1;
  endtask

  task automatic test_alu();
    cyc_t c;
    int k = 0;
    do_instr(8'b00000_011, 0, 0, 0, 4'b0010);
    do_instr(8'b00111_000, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 6; i++)
      do_instr({1'b0, 7'($urandom)}, $urandom_range(0, 2), 0, 0, rndf());
    while (q.size() > 0) begin
      play(c);
      nTotal++;
      if (act !== c.exp) $display("FAIL alu[%0d]: got %h expected %h", k, act, c.exp);
      else nPass++;
      k++;
    end
  endtask

  task automatic test_load();
    cyc_t c;
    int k = 0;
    do_instr({3'b100, 5'($urandom)}, 0, 3, 0, 4'b0000);
    do_instr({3'b100, 5'($urandom)}, 2, 0, 0, 4'b0000);
    while (q.size() > 0) begin
      play(c);
      nTotal++;
      if (act !== c.exp) $display("FAIL load[%0d]: got %h expected %h", k, act, c.exp);
      else nPass++;
      k++;
    end
  endtask

  task automatic test_store();
    cyc_t c;
    int k = 0;
    do_instr({3'b101, 5'($urandom)}, 1, 2, 0, 4'b0000);
    do_instr({3'b101, 5'($urandom)}, 0, 0, 0, 4'b0000);
    while (q.size() > 0) begin
      play(c);
      nTotal++;
      if (act !== c.exp) $display("FAIL store[%0d]: got %h expected %h", k, act, c.exp);
      else nPass++;
      k++;
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    int k = 0;
    do_instr(8'b00000_000, 0, 0, 0, 4'b1110);
    do_instr(8'b11000_001, 0, 0, 0, 4'b0000);
    do_instr(8'b00000_000, 0, 0, 0, 4'b0001);
    do_instr(8'b11000_001, 0, 0, 0, 4'b0000);
    do_instr(8'b11000_010, 0, 0, 0, 4'b0000);
    do_instr(8'b11001_111, 0, 0, 0, 4'b0000);
    do_instr(8'b11010_000, 0, 0, 0, 4'b0000);
    while (q.size() > 0) begin
      play(c);
      nTotal++;
      if (act !== c.exp) $display("FAIL branch[%0d]: got %h expected %h", k, act, c.exp);
      else nPass++;
      k++;
    end
  endtask

  task automatic test_interrupt();
    cyc_t c;
    int k = 0;
    mOp = {3'b100, 5'($urandom)};
    gen_fetch(0);
    gen_fetch_data(1, 2);
    gen_exec(2, 2, 4'b0000);
    do_instr(8'b00001_000, 0, 0, 2, 4'b0000);
    do_instr(8'b00010_000, 0, 0, 2, 4'b0000);
    do_instr(8'b11011_000, 0, 0, 2, 4'b0000);
    do_instr(8'b00000_000, 0, 0, 2, 4'b0000);
    while (q.size() > 0) begin
      play(c);
      nTotal++;
      if (act !== c.exp) $display("FAIL interrupt[%0d]: got %h expected %h", k, act, c.exp);
      else nPass++;
      k++;
    end
  endtask

  task automatic test_reset_mid_wait();
    cyc_t c;
    int k = 0;
    do_instr(8'b00000_000, 0, 0, 0, 4'b0010);
    mOp = {3'b100, 5'($urandom)};
    gen_fetch(0);
    gen_fetch_data(0, 0);
    gen_exec(5, 0, 4'b0000);
    for (int i = 0; i < 4; i++) void'(q.pop_back());
    push(dflt(), 1'b1, 1'b1, 1'b1, rndf());
    mFlags = 4'b0000;
    mIe = 1'b1;
    do_instr(8'b00000_000, 0, 0, 0, 4'b0100);
    while (q.size() > 0) begin
      play(c);
      nTotal++;
      if (act !== c.exp) $display("FAIL reset_mid_wait[%0d]: got %h expected %h", k, act, c.exp);
      else nPass++;
      k++;
    end
  endtask

  task automatic test_random();
    cyc_t c;
    int k = 0;
    for (int i = 0; i < 150; i++)
      do_instr(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1, rndf());
    while (q.size() > 0) begin
      play(c);
      nTotal++;
      if (act !== c.exp) $display("FAIL random[%0d]: got %h expected %h", k, act, c.exp);
      else nPass++;
      k++;
    end
  endtask

  initial begin
    Reset = 1'b1; Opcode = 8'h00; Flags = 4'h0; IntReq = 1'b0; MemReady = 1'b0;
    nPass = 0; nTotal = 0; mFlags = 4'b0000; mIe = 1'b1; mOp = 8'h00;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_interrupt();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 No parameters.
REQ-002 Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  8  IR[15:8] from the datapath; [7:3] class/function, [2:0] Rd or condition.
REQ-005 Flags  input  4  ALU flags: [0]=Z, [1]=C, [2]=N, [3]=V.
REQ-006 IntReq  input  1  level interrupt request.
REQ-007 MemReady  input  1  memory data-phase complete.
REQ-008 AluOp  output  alu_functions_t  ALU function.
REQ-009 PcSel, Op1Sel, Op2Sel, ImmSel, WdSel, Rs1Sel, LrSel  output  opcodes enum types  datapath mux selects, one port each.
REQ-010 AluEn, AluWe, LrEn, LrWe, PcEn, PcWe, IrWe, RegWe, MemEn  output  1 each  datapath enables, one port each.
REQ-011 CFlag  output  1  stored carry, to the ALU carry-in.
REQ-012 AddrLatch  output  1  SysBus carries an address this cycle.
REQ-013 MemRd  output  1  read data phase.
REQ-014 MemWr  output  1  write data phase.
REQ-015 IntAck  output  1  one-cycle interrupt acknowledge.
REQ-016 Illegal  output  1  one-cycle undefined-opcode pulse.
REQ-017 Halted  output  1  high while in HALT.
REQ-018 RwSel=RwRd, FlagSel=FlagAlu and FlagListen=0 SHALL be tied at the top level.

Function
REQ-019 Default outputs: every enable, AddrLatch, MemRd, MemWr, IntAck and Illegal = 0; selects Op1Rd1, Op2Rd2, Pc1, Rs1Rd, WdAlu, ImmShort, LrPc.
REQ-020 States: FETCH_A, FETCH_D, EXEC, MEM_A, MEM_RD, ST_PREP, MEM_WR, INT, HALT.
REQ-021 FETCH_A: if IntReq and IE are both 1 -> INT. Otherwise PcEn=1 and AddrLatch=1 -> FETCH_D.
REQ-022 FETCH_D: MemEn=1 and MemRd=1 on every cycle. Stay while MemReady=0. On MemReady=1: IrWe=1, PcWe=1 (Pc1) -> EXEC.
REQ-023 Opcode[7:6]=00 ALU reg-reg: AluOp = Opcode[5:3] zero-extended to alu_functions_t, RegWe=1, flag register <= Flags, -> FETCH_A.
REQ-024 Opcode[7:6]=01 ALU immediate: as REQ-023 with Op2Imm and ImmShort.
REQ-025 Opcode[7:5]=100 (load) and 101 (store), EXEC: Rs1Ra, Op2Imm, ImmShort, ADD, AluWe=1 -> MEM_A.
REQ-026 MEM_A: AluEn=1, AddrLatch=1. Load -> MEM_RD; store -> ST_PREP.
REQ-027 MEM_RD: MemEn=1, MemRd=1; wait for MemReady. On MemReady: WdSys, RegWe=1 -> FETCH_A.
REQ-028 ST_PREP: Rs1Rd, Op2zero, ADD, AluWe=1 -> MEM_WR.
REQ-029 MEM_WR: AluEn=1, MemWr=1; wait for MemReady, then -> FETCH_A.
REQ-030 Opcode[7:3]=11000 branch, condition Opcode[2:0]: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 N, 110 !N, 111 never.
REQ-031 Taken branch: Op1Pc, Op2Imm, ImmLong, ADD, PcSel=PcAluOut, PcWe=1. Target is the already-incremented Pc + sext(IR[7:0]). Not taken: no write. Either way -> FETCH_A.
REQ-032 11001 BL: LrPc-style save of the incremented Pc (LrSel=LrPc on Pc, LrWe=1) plus the taken-branch controls of REQ-031 -> FETCH_A.
REQ-033 11010 RET: PcSel=PcLr, PcWe=1 -> FETCH_A.
REQ-034 11011 RETI: as RET, and IE <= 1.
REQ-035 11100 -> HALT.
REQ-036 11101-11111: Illegal=1 for one cycle, no state write -> FETCH_A.
REQ-037 Flag register updates only per REQ-023/REQ-024. Condition evaluation and CFlag use the stored flags, never the live Flags input.
REQ-038 INT, single cycle: PcEn=1, LrSel=LrSys, LrWe=1 (LR <= return Pc); PcSel=PcInt, PcWe=1 (Pc <= 0x0010); IE <= 0; IntAck=1 -> FETCH_A.
REQ-039 HALT: Halted=1. Exit only via IntReq with IE=1, to INT; otherwise remain until Reset.
REQ-040 Unlimited MemReady wait: no timeout.
REQ-041 IntReq is sampled only in FETCH_A, so in-flight instructions always complete.

Reset
REQ-042 Reset=1 at an edge SHALL force FETCH_A, flags=0, IE=1 and all outputs to REQ-019 defaults, in any state including mid-wait, overriding MemReady and IntReq.

Verification
REQ-043 Reset, 0-wait memory, ADD reg-reg -> FETCH_A,FETCH_D,EXEC over 3 cycles; RegWe=1 in EXEC; CFlag follows Flags[1].
REQ-044 Load with MemReady low for 3 cycles -> MemRd/MemEn high 4 cycles; RegWe only on the MemReady cycle.
REQ-045 Store -> AddrLatch with AluEn, then ST_PREP, then MemWr with AluEn until MemReady.
REQ-046 Branch cond 001 with Z=0 -> no PcWe; with Z=1 -> PcWe with PcAluOut.
REQ-047 IntReq=1 during a load -> load completes; INT next with PcInt and IntAck pulse. Second IntReq ignored until RETI restores IE.
REQ-048 Reset asserted in MEM_RD wait -> next cycle FETCH_A, MemRd=0, no RegWe.
